// File: rtl/sid_reg_pkg.sv
// rtl/sid_reg_pkg.sv - SID register map addresses and voice register offsets
package sid_reg_pkg;

    localparam logic [4:0] SID_FREQ_LO  = 5'h00;
    localparam logic [4:0] SID_FREQ_HI  = 5'h01;
    localparam logic [4:0] SID_PW_LO    = 5'h02;
    localparam logic [4:0] SID_PW_HI    = 5'h03;
    localparam logic [4:0] SID_CONTROL  = 5'h04;
    localparam logic [4:0] SID_ATT_DEC  = 5'h05;
    localparam logic [4:0] SID_SUS_REL  = 5'h06;
    localparam logic [4:0] SID_FC_LO    = 5'h15;
    localparam logic [4:0] SID_FC_HI    = 5'h16;
    localparam logic [4:0] SID_RES_FILT = 5'h17;
    localparam logic [4:0] SID_MODE_VOL = 5'h18;
    localparam logic [4:0] SID_POTX     = 5'h19;
    localparam logic [4:0] SID_POTY     = 5'h1A;
    localparam logic [4:0] SID_OSC3     = 5'h1B;
    localparam logic [4:0] SID_ENV3     = 5'h1C;

    localparam int VOICE_STRIDE = 7;

    typedef enum logic [2:0] {
        VR_FREQ_LO = 3'd0,
        VR_FREQ_HI = 3'd1,
        VR_PW_LO   = 3'd2,
        VR_PW_HI   = 3'd3,
        VR_CONTROL = 3'd4,
        VR_ATT_DEC = 3'd5,
        VR_SUS_REL = 3'd6
    } voice_reg_e;

endpackage

// File: rtl/sid_voice_regs.sv
// rtl/sid_voice_regs.sv - one voice's 7-register bank located at address BASE
module sid_voice_regs
    import sid_reg_pkg::*;
#(
    parameter logic [4:0] BASE = 5'h00
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       wr_en_i,
    input  logic [4:0] addr_i,
    input  logic [7:0] data_i,
    output logic [7:0] freq_lo_o,
    output logic [7:0] freq_hi_o,
    output logic [7:0] pw_lo_o,
    output logic [3:0] pw_hi_o,
    output logic [7:0] control_o,
    output logic [7:0] att_dec_o,
    output logic [7:0] sus_rel_o
);

    logic [7:0] freq_lo_q, freq_lo_d, freq_hi_q, freq_hi_d, pw_lo_q, pw_lo_d;
    logic [3:0] pw_hi_q, pw_hi_d;
    logic [7:0] control_q, control_d, att_dec_q, att_dec_d, sus_rel_q, sus_rel_d;
    logic [4:0] offset;
    logic       hit;

    // Addresses below BASE wrap to large offsets, so one compare covers both bounds.
    assign offset = addr_i - BASE;
    assign hit    = wr_en_i && (offset < 5'(VOICE_STRIDE));

    always_comb begin
        freq_lo_d = freq_lo_q;
        freq_hi_d = freq_hi_q;
        pw_lo_d   = pw_lo_q;
        pw_hi_d   = pw_hi_q;
        control_d = control_q;
        att_dec_d = att_dec_q;
        sus_rel_d = sus_rel_q;
        if (hit) begin
            case (voice_reg_e'(offset[2:0]))
                VR_FREQ_LO: freq_lo_d = data_i;
                VR_FREQ_HI: freq_hi_d = data_i;
                VR_PW_LO:   pw_lo_d   = data_i;
                VR_PW_HI:   pw_hi_d   = data_i[3:0];
                VR_CONTROL: control_d = data_i;
                VR_ATT_DEC: att_dec_d = data_i;
                VR_SUS_REL: sus_rel_d = data_i;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            freq_lo_q <= '0;
            freq_hi_q <= '0;
            pw_lo_q   <= '0;
            pw_hi_q   <= '0;
            control_q <= '0;
            att_dec_q <= '0;
            sus_rel_q <= '0;
        end else begin
            freq_lo_q <= freq_lo_d;
            freq_hi_q <= freq_hi_d;
            pw_lo_q   <= pw_lo_d;
            pw_hi_q   <= pw_hi_d;
            control_q <= control_d;
            att_dec_q <= att_dec_d;
            sus_rel_q <= sus_rel_d;
        end
    end

    assign freq_lo_o = freq_lo_q;
    assign freq_hi_o = freq_hi_q;
    assign pw_lo_o   = pw_lo_q;
    assign pw_hi_o   = pw_hi_q;
    assign control_o = control_q;
    assign att_dec_o = att_dec_q;
    assign sus_rel_o = sus_rel_q;

endmodule

// File: rtl/sid_reg_if.sv
// rtl/sid_reg_if.sv - SID CPU register file, readback and bus latch; SID_BUS_DECAY_EN adds latch decay
module sid_reg_if
    import sid_reg_pkg::*;
#(
    parameter logic [23:0] DECAY_CYCLES = 24'd2000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ce_1m,
    input  logic        cs,
    input  logic        we,
    input  logic [4:0]  addr,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out,
    input  logic [7:0]  osc3,
    input  logic [7:0]  env3,
    input  logic [7:0]  pot_x,
    input  logic [7:0]  pot_y,
    output logic [23:0] freq_lo,
    output logic [23:0] freq_hi,
    output logic [23:0] pw_lo,
    output logic [11:0] pw_hi,
    output logic [23:0] control,
    output logic [23:0] att_dec,
    output logic [23:0] sus_rel,
    output logic [2:0]  fc_lo,
    output logic [7:0]  fc_hi,
    output logic [7:0]  res_filt,
    output logic [7:0]  mode_vol
);

    logic [2:0] fc_lo_q, fc_lo_d;
    logic [7:0] fc_hi_q, fc_hi_d, res_filt_q, res_filt_d, mode_vol_q, mode_vol_d;
    logic [7:0] latch_q, latch_d, data_out_q, data_out_d;
    logic [7:0] rb_val;
    logic       rb_hit;

    for (genvar g = 0; g < 3; g++) begin : g_voice
        sid_voice_regs #(.BASE(5'(g * VOICE_STRIDE))) u_regs (
            .clock     (clock),
            .reset     (reset),
            .wr_en_i   (cs && we),
            .addr_i    (addr),
            .data_i    (data_in),
            .freq_lo_o (freq_lo[8*g +: 8]),
            .freq_hi_o (freq_hi[8*g +: 8]),
            .pw_lo_o   (pw_lo[8*g +: 8]),
            .pw_hi_o   (pw_hi[4*g +: 4]),
            .control_o (control[8*g +: 8]),
            .att_dec_o (att_dec[8*g +: 8]),
            .sus_rel_o (sus_rel[8*g +: 8])
        );
    end

`ifdef SID_BUS_DECAY_EN
    logic [23:0] decay_cnt_q, decay_cnt_d;
    logic        decay_tick, decay_expire;
    // Counter saturates at the terminal value; the latch clears on the tick that reaches it.
    assign decay_tick   = ce_1m && (decay_cnt_q != DECAY_CYCLES - 24'd1);
    assign decay_expire = decay_tick && (decay_cnt_q + 24'd1 == DECAY_CYCLES - 24'd1);
`else
    logic unused_decay;
    assign unused_decay = ^{DECAY_CYCLES, ce_1m};
`endif

    always_comb begin
        rb_hit = 1'b1;
        rb_val = latch_q;
        case (addr)
            SID_POTX: rb_val = pot_x;
            SID_POTY: rb_val = pot_y;
            SID_OSC3: rb_val = osc3;
            SID_ENV3: rb_val = env3;
            default:  rb_hit = 1'b0;
        endcase
    end

    always_comb begin
        fc_lo_d    = fc_lo_q;
        fc_hi_d    = fc_hi_q;
        res_filt_d = res_filt_q;
        mode_vol_d = mode_vol_q;
        latch_d    = latch_q;
        data_out_d = data_out_q;
`ifdef SID_BUS_DECAY_EN
        decay_cnt_d = decay_tick ? decay_cnt_q + 24'd1 : decay_cnt_q;
        if (decay_expire) latch_d = '0;
`endif
        if (cs && we) begin
            latch_d = data_in;
`ifdef SID_BUS_DECAY_EN
            decay_cnt_d = '0;
`endif
            case (addr)
                SID_FC_LO:    fc_lo_d    = data_in[2:0];
                SID_FC_HI:    fc_hi_d    = data_in;
                SID_RES_FILT: res_filt_d = data_in;
                SID_MODE_VOL: mode_vol_d = data_in;
                default: ;
            endcase
        end else if (cs) begin
            data_out_d = rb_val;
            if (rb_hit) begin
                latch_d = rb_val;
`ifdef SID_BUS_DECAY_EN
                decay_cnt_d = '0;
`endif
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fc_lo_q     <= '0;
            fc_hi_q     <= '0;
            res_filt_q  <= '0;
            mode_vol_q  <= '0;
            latch_q     <= '0;
            data_out_q  <= '0;
`ifdef SID_BUS_DECAY_EN
            decay_cnt_q <= '0;
`endif
        end else begin
            fc_lo_q     <= fc_lo_d;
            fc_hi_q     <= fc_hi_d;
            res_filt_q  <= res_filt_d;
            mode_vol_q  <= mode_vol_d;
            latch_q     <= latch_d;
            data_out_q  <= data_out_d;
`ifdef SID_BUS_DECAY_EN
            decay_cnt_q <= decay_cnt_d;
`endif
        end
    end

    assign fc_lo    = fc_lo_q;
    assign fc_hi    = fc_hi_q;
    assign res_filt = res_filt_q;
    assign mode_vol = mode_vol_q;
    assign data_out = data_out_q;

endmodule

// File: tb/tb_sid_reg_if.sv
// tb/tb_sid_reg_if.sv - table-driven scoreboard bench for sid_reg_if
module tb_sid_reg_if;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ce_1m = 1'b0;
    logic        cs = 1'b0;
    logic        we = 1'b0;
    logic [4:0]  addr = '0;
    logic [7:0]  data_in = '0;
    logic [7:0]  data_out;
    logic [7:0]  osc3 = '0, env3 = '0, pot_x = '0, pot_y = '0;
    logic [23:0] freq_lo, freq_hi, pw_lo, control, att_dec, sus_rel;
    logic [11:0] pw_hi;
    logic [2:0]  fc_lo;
    logic [7:0]  fc_hi, res_filt, mode_vol;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic       wr;
        logic [4:0] a;
        logic [7:0] d;
        logic [7:0] exp;
    } vec_t;

    sid_reg_if #(.DECAY_CYCLES(24'd16)) dut (
        .clock(clock), .reset(reset), .ce_1m(ce_1m), .cs(cs), .we(we),
        .addr(addr), .data_in(data_in), .data_out(data_out),
        .osc3(osc3), .env3(env3), .pot_x(pot_x), .pot_y(pot_y),
        .freq_lo(freq_lo), .freq_hi(freq_hi), .pw_lo(pw_lo), .pw_hi(pw_hi),
        .control(control), .att_dec(att_dec), .sus_rel(sus_rel),
        .fc_lo(fc_lo), .fc_hi(fc_hi), .res_filt(res_filt), .mode_vol(mode_vol)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic access(input logic w, input logic [4:0] a, input logic [7:0] d);
        @(negedge clock);
        cs = 1'b1; we = w; addr = a; data_in = d;
        @(negedge clock);
        cs = 1'b0; we = 1'b0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [7:0] d);
        access(1'b1, a, d);
    endtask

    task automatic rd(input string name, input logic [4:0] a, input logic [7:0] exp);
        logic [7:0] e;
        exp_q.push_back(exp);
        access(1'b0, a, 8'h00);
        if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = exp_q.pop_front();
            check(name, {16'h0, data_out}, {16'h0, e});
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock); ce_1m = 1'b1;
            @(negedge clock); ce_1m = 1'b0;
        end
    endtask

    vec_t vecs[$];

    initial begin
        // {write?, addr, data, expected read data}
        vecs.push_back('{1'b1, 5'h04, 8'h41, 8'h00});
        vecs.push_back('{1'b1, 5'h0B, 8'h11, 8'h00});
        vecs.push_back('{1'b1, 5'h12, 8'h81, 8'h00});
        vecs.push_back('{1'b1, 5'h03, 8'hFF, 8'h00});
        vecs.push_back('{1'b1, 5'h15, 8'hFF, 8'h00});
        vecs.push_back('{1'b0, 5'h03, 8'h00, 8'hFF});
        vecs.push_back('{1'b0, 5'h1B, 8'h00, 8'h5A});
        vecs.push_back('{1'b0, 5'h00, 8'h00, 8'h5A});
        vecs.push_back('{1'b1, 5'h18, 8'h0F, 8'h00});
        vecs.push_back('{1'b0, 5'h1D, 8'h00, 8'h0F});
        vecs.push_back('{1'b0, 5'h19, 8'h00, 8'h3C});
        vecs.push_back('{1'b0, 5'h1A, 8'h00, 8'hC3});
        vecs.push_back('{1'b0, 5'h1C, 8'h00, 8'h77});
        vecs.push_back('{1'b0, 5'h14, 8'h00, 8'h77});

        osc3 = 8'h5A; env3 = 8'h77; pot_x = 8'h3C; pot_y = 8'hC3;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("reset_data_out", {16'h0, data_out}, 24'h0);
        check("reset_control", control, 24'h0);
        check("reset_freq_lo", freq_lo, 24'h0);
        check("reset_pw_hi", {12'h0, pw_hi}, 24'h0);
        check("reset_filter", {fc_lo, fc_hi, res_filt, mode_vol}, 24'h0);
        rd("reset_latch", 5'h00, 8'h00);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].wr) wr(vecs[i].a, vecs[i].d);
            else rd($sformatf("vec%0d_rd_%h", i, vecs[i].a), vecs[i].a, vecs[i].exp);
            if (i == 2) begin
                check("control_packed", control, 24'h811141);
                check("others_zero", freq_lo | freq_hi | pw_lo | att_dec | sus_rel, 24'h0);
            end
        end
        check("pw_hi_masked", {12'h0, pw_hi}, 24'h00000F);
        check("fc_lo_masked", {21'h0, fc_lo}, 24'h7);
        check("mode_vol", {16'h0, mode_vol}, 24'h00000F);

        // Unused-address write: latch only, data_out holds last read value
        wr(5'h1F, 8'h33);
        check("unused_wr_hold", {16'h0, data_out}, 24'h000077);
        check("unused_wr_regs", {fc_hi, res_filt, mode_vol}, 24'h00000F);
        rd("unused_wr_latch", 5'h1E, 8'h33);

        // Readback samples the live input at the access edge
        osc3 = 8'hA5;
        rd("osc3_live", 5'h1B, 8'hA5);
        rd("osc3_latch", 5'h1D, 8'hA5);

`ifdef SID_BUS_DECAY_EN
        wr(5'h00, 8'hAA);
        tick(14);
        rd("decay_14", 5'h00, 8'hAA);
        tick(1);
        rd("decay_15", 5'h00, 8'h00);
        tick(5);
        rd("decay_sat", 5'h00, 8'h00);
        wr(5'h00, 8'h55);
        tick(14);
        @(negedge clock);
        cs = 1'b1; we = 1'b1; addr = 5'h01; data_in = 8'h66; ce_1m = 1'b1;
        @(negedge clock);
        cs = 1'b0; we = 1'b0; ce_1m = 1'b0;
        rd("decay_write_wins", 5'h00, 8'h66);
        tick(14);
        rd("decay_restart", 5'h00, 8'h66);
`else
        wr(5'h00, 8'hAA);
        tick(40);
        rd("latch_no_decay", 5'h00, 8'hAA);
`endif

        // Every voice register with a distinct value
        for (int v = 0; v < 3; v++)
            for (int r = 0; r < 7; r++)
                wr(5'(v * 7 + r), 8'(8'h10 * (v + 1) + r));
        check("all_freq_lo", freq_lo, 24'h302010);
        check("all_freq_hi", freq_hi, 24'h312111);
        check("all_pw_lo", pw_lo, 24'h322212);
        check("all_pw_hi", {12'h0, pw_hi}, 24'h000333);
        check("all_control", control, 24'h342414);
        check("all_att_dec", att_dec, 24'h352515);
        check("all_sus_rel", sus_rel, 24'h362616);

        // Reset wins over a simultaneous write
        wr(5'h16, 8'h12);
        check("fc_hi_set", {16'h0, fc_hi}, 24'h000012);
        @(negedge clock);
        reset = 1'b1; cs = 1'b1; we = 1'b1; addr = 5'h16; data_in = 8'h77;
        @(negedge clock);
        reset = 1'b0; cs = 1'b0; we = 1'b0;
        @(negedge clock);
        check("rst_fc_hi", {16'h0, fc_hi}, 24'h0);
        check("rst_data_out", {16'h0, data_out}, 24'h0);
        check("rst_control", control, 24'h0);
        rd("rst_latch", 5'h1D, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
